// File: rtl/timer_pkg.sv
// Shared constants and types for the anti-theft timer slice.
package timer_pkg;

  localparam int unsigned TIME_W = 4;

  typedef logic [TIME_W-1:0] time_t;

  typedef enum logic [1:0] {
    INT_ARM    = 2'b00,
    INT_DRIVER = 2'b01,
    INT_PASS   = 2'b10,
    INT_ALARM  = 2'b11
  } interval_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Power-on durations in seconds, shared with the alarm FSM and siren generator.
  localparam time_t T_ARM_DEFAULT    = 4'd6;
  localparam time_t T_DRIVER_DEFAULT = 4'd8;
  localparam time_t T_PASS_DEFAULT   = 4'd15;
  localparam time_t T_ALARM_DEFAULT  = 4'd10;

endpackage

// File: rtl/timer_sequencer_if.sv
// Control/status bundle between the alarm FSM side and the timer block.
interface timer_sequencer_if;
  import timer_pkg::*;

  logic        start_timer;
  logic [1:0]  interval;
  logic        reprogram;
  logic [1:0]  time_param_sel;
  time_t       time_value;
  logic        expired;
  logic        busy;
  time_t       value;
  logic        one_hz_enable;
  logic        two_hz_enable;

  modport master (
    output start_timer, interval, reprogram, time_param_sel, time_value,
    input  expired, busy, value, one_hz_enable, two_hz_enable
  );

  modport slave (
    input  start_timer, interval, reprogram, time_param_sel, time_value,
    output expired, busy, value, one_hz_enable, two_hz_enable
  );

endinterface

// File: rtl/timer_sequencer_clock_divider.sv
// Free-running divider producing registered 1 Hz and 2 Hz enable strobes.
module clock_divider #(
  parameter int unsigned CLK_FREQ = 50_000_000
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  output logic one_hz_enable,
  output logic two_hz_enable
);

  localparam int unsigned DIV_W = $clog2(CLK_FREQ);
  localparam logic [DIV_W-1:0] LAST = DIV_W'(CLK_FREQ - 1);
  localparam logic [DIV_W-1:0] HALF = DIV_W'(CLK_FREQ / 2 - 1);

  logic [DIV_W-1:0] div;
  logic [DIV_W-1:0] div_nxt;

  // Next divider value: clear wins, otherwise wrap at CLK_FREQ-1.
  always_comb begin
    div_nxt = div + 1'b1;
    if (clear) begin
      div_nxt = '0;
    end else if (div == LAST) begin
      div_nxt = '0;
    end
  end

  // Strobes are decoded from the next count so they are high in the same
  // cycle the divider holds the matching value, while still being registered.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      div           <= '0;
      one_hz_enable <= 1'b0;
      two_hz_enable <= 1'b0;
    end else begin
      div           <= div_nxt;
      one_hz_enable <= (div_nxt == LAST);
      two_hz_enable <= (div_nxt == LAST) || (div_nxt == HALF);
    end
  end

endmodule

// File: rtl/timer_sequencer.sv
// Countdown timer with four programmable durations and 1 Hz / 2 Hz strobes.
module timer_sequencer
  import timer_pkg::*;
#(
  parameter int unsigned CLK_FREQ     = 50_000_000,
  parameter time_t       T_ARM_DEF    = T_ARM_DEFAULT,
  parameter time_t       T_DRIVER_DEF = T_DRIVER_DEFAULT,
  parameter time_t       T_PASS_DEF   = T_PASS_DEFAULT,
  parameter time_t       T_ALARM_DEF  = T_ALARM_DEFAULT
) (
  input logic               clock,
  input logic               reset,
  timer_sequencer_if.slave  bus
);

  state_t state;
  state_t state_nxt;
  time_t  count;
  time_t  count_nxt;
  time_t  param [4];
  logic   one_hz;
  logic   two_hz;
  logic   start_accepted;

  // A start coinciding with a reprogram is dropped, so it must not clear the divider.
  assign start_accepted = bus.start_timer && !bus.reprogram;

  clock_divider #(
    .CLK_FREQ (CLK_FREQ)
  ) u_div (
    .clock         (clock),
    .reset         (reset),
    .clear         (start_accepted),
    .one_hz_enable (one_hz),
    .two_hz_enable (two_hz)
  );

  // Duration registers; zero writes are rejected so a loaded count is never 0.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      param[0] <= T_ARM_DEF;
      param[1] <= T_DRIVER_DEF;
      param[2] <= T_PASS_DEF;
      param[3] <= T_ALARM_DEF;
    end else if (bus.reprogram && (bus.time_value != '0)) begin
      param[bus.time_param_sel] <= bus.time_value;
    end
  end

  // State and count registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      count <= '0;
    end else begin
      state <= state_nxt;
      count <= count_nxt;
    end
  end

  // Next state: reprogram beats start, start beats the 1 Hz tick.
  always_comb begin
    state_nxt = state;
    count_nxt = count;
    if (bus.reprogram) begin
      state_nxt = IDLE;
      count_nxt = '0;
    end else if (bus.start_timer) begin
      state_nxt = COUNT;
      count_nxt = param[bus.interval];
    end else if ((state == COUNT) && one_hz) begin
      if (count > 4'd1) begin
        count_nxt = count - 4'd1;
      end else begin
        count_nxt = '0;
        state_nxt = DONE;
      end
    end
  end

  // Outputs decode registered state only.
  always_comb begin
    bus.busy          = (state == COUNT);
    bus.expired       = (state == DONE);
    bus.value         = count;
    bus.one_hz_enable = one_hz;
    bus.two_hz_enable = two_hz;
  end

endmodule

// File: tb/tb_timer_sequencer.sv
// Directed bench for timer_sequencer with CLK_FREQ=8.
module tb_timer_sequencer;

  logic clock;
  logic reset;
  int   total;
  int   bad;

  timer_sequencer_if bus ();

  timer_sequencer #(
    .CLK_FREQ (8)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic       st;
    logic [1:0] iv;
    logic       rp;
    logic [1:0] sel;
    logic [3:0] tv;
    int         idle;
    logic       e_busy;
    logic       e_exp;
    logic [3:0] e_val;
    logic       e_one;
    logic       e_two;
  } vec_t;

  vec_t vecs [15];

  task automatic check(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic idle_inputs();
    bus.start_timer    = 1'b0;
    bus.interval       = 2'b00;
    bus.reprogram      = 1'b0;
    bus.time_param_sel = 2'b00;
    bus.time_value     = 4'd0;
  endtask

  task automatic do_start(input logic [1:0] iv);
    bus.start_timer = 1'b1;
    bus.interval    = iv;
    tick(1);
    idle_inputs();
  endtask

  initial begin
    total = 0;
    bad   = 0;
    idle_inputs();
    reset = 1'b0;

    // start, interval, reprogram, sel, value, extra idle edges, busy, expired, value, 1Hz, 2Hz
    vecs[0]  = '{1'b1, 2'd0, 1'b0, 2'd0, 4'd0,  0, 1'b1, 1'b0, 4'd6, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 2'd0, 1'b0, 2'd0, 4'd0,  6, 1'b1, 1'b0, 4'd6, 1'b1, 1'b1};
    vecs[2]  = '{1'b0, 2'd0, 1'b0, 2'd0, 4'd0,  0, 1'b1, 1'b0, 4'd5, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 2'd0, 1'b0, 2'd0, 4'd0, 31, 1'b1, 1'b0, 4'd1, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, 2'd0, 1'b0, 2'd0, 4'd0,  6, 1'b1, 1'b0, 4'd1, 1'b1, 1'b1};
    vecs[5]  = '{1'b0, 2'd0, 1'b0, 2'd0, 4'd0,  0, 1'b0, 1'b1, 4'd0, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, 2'd0, 1'b0, 2'd0, 4'd0,  8, 1'b0, 1'b1, 4'd0, 1'b0, 1'b0};
    vecs[7]  = '{1'b0, 2'd0, 1'b1, 2'd2, 4'd3,  0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0};
    vecs[8]  = '{1'b1, 2'd2, 1'b0, 2'd0, 4'd0,  0, 1'b1, 1'b0, 4'd3, 1'b0, 1'b0};
    vecs[9]  = '{1'b0, 2'd0, 1'b0, 2'd0, 4'd0, 22, 1'b1, 1'b0, 4'd1, 1'b1, 1'b1};
    vecs[10] = '{1'b0, 2'd0, 1'b0, 2'd0, 4'd0,  0, 1'b0, 1'b1, 4'd0, 1'b0, 1'b0};
    vecs[11] = '{1'b0, 2'd0, 1'b1, 2'd2, 4'd0,  0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0};
    vecs[12] = '{1'b1, 2'd2, 1'b0, 2'd0, 4'd0,  0, 1'b1, 1'b0, 4'd3, 1'b0, 1'b0};
    vecs[13] = '{1'b0, 2'd0, 1'b0, 2'd0, 4'd0, 22, 1'b1, 1'b0, 4'd1, 1'b1, 1'b1};
    vecs[14] = '{1'b0, 2'd0, 1'b0, 2'd0, 4'd0,  0, 1'b0, 1'b1, 4'd0, 1'b0, 1'b0};

    // Reset state
    #12;
    check("rst_busy",    bus.busy,          0);
    check("rst_expired", bus.expired,       0);
    check("rst_value",   bus.value,         0);
    check("rst_one_hz",  bus.one_hz_enable, 0);
    check("rst_two_hz",  bus.two_hz_enable, 0);

    // Free-running strobes after reset release
    @(negedge clock);
    reset = 1'b1;
    for (int cyc = 1; cyc <= 20; cyc++) begin
      tick(1);
      check("idle_one_hz",  bus.one_hz_enable, ((cyc % 8) == 7) ? 1 : 0);
      check("idle_two_hz",  bus.two_hz_enable, ((cyc % 4) == 3) ? 1 : 0);
      check("idle_expired", bus.expired, 0);
      check("idle_value",   bus.value,   0);
    end

    // Table: default arm countdown, reprogram, rejected zero write
    for (int i = 0; i < 15; i++) begin
      bus.start_timer    = vecs[i].st;
      bus.interval       = vecs[i].iv;
      bus.reprogram      = vecs[i].rp;
      bus.time_param_sel = vecs[i].sel;
      bus.time_value     = vecs[i].tv;
      tick(1);
      idle_inputs();
      tick(vecs[i].idle);
      check($sformatf("vec%0d_busy", i),    bus.busy,          vecs[i].e_busy);
      check($sformatf("vec%0d_expired", i), bus.expired,       vecs[i].e_exp);
      check($sformatf("vec%0d_value", i),   bus.value,         vecs[i].e_val);
      check($sformatf("vec%0d_one_hz", i),  bus.one_hz_enable, vecs[i].e_one);
      check($sformatf("vec%0d_two_hz", i),  bus.two_hz_enable, vecs[i].e_two);
    end

    // Restart mid-count reloads the count and clears the divider
    do_start(2'd3);
    tick(19);
    check("pre_restart_value", bus.value, 8);
    do_start(2'd1);
    check("restart_value", bus.value, 8);
    check("restart_busy",  bus.busy,  1);
    tick(3);
    check("restart_no_early_tick", bus.one_hz_enable, 0);
    tick(4);
    check("restart_first_tick", bus.one_hz_enable, 1);
    check("restart_value_r7",   bus.value, 8);
    tick(1);
    check("restart_value_r8", bus.value, 7);
    tick(55);
    check("restart_value_r63",   bus.value,   1);
    check("restart_expired_r63", bus.expired, 0);
    tick(1);
    check("restart_expired_r64", bus.expired, 1);

    // Reprogram and start on the same edge mid-count
    do_start(2'd0);
    tick(10);
    bus.reprogram      = 1'b1;
    bus.time_param_sel = 2'd0;
    bus.time_value     = 4'd5;
    bus.start_timer    = 1'b1;
    bus.interval       = 2'd0;
    tick(1);
    idle_inputs();
    check("both_busy",    bus.busy,    0);
    check("both_expired", bus.expired, 0);
    check("both_value",   bus.value,   0);
    tick(20);
    check("both_still_idle", bus.busy,  0);
    check("both_still_zero", bus.value, 0);
    do_start(2'd0);
    check("both_param_written", bus.value, 5);

    // Asynchronous reset mid-count
    tick(3);
    #3;
    reset = 1'b0;
    #1;
    check("arst_busy",    bus.busy,          0);
    check("arst_expired", bus.expired,       0);
    check("arst_value",   bus.value,         0);
    check("arst_one_hz",  bus.one_hz_enable, 0);
    @(negedge clock);
    reset = 1'b1;
    do_start(2'd0);
    check("arst_arm_default", bus.value, 6);
    do_start(2'd2);
    check("arst_pass_default", bus.value, 15);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
